// File: rtl/alu_seq_reader.sv
// Sequential calculator ALU: samples operands and op on a start pulse in IDLE,
// finishes add/sub in one cycle and mul/div in W cycles; results held until the next op.
module alu_seq_reader #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   remainder,
  output logic           carry,
  output logic           neg,
  output logic           div_by_zero
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [1:0]     op_q, op_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  // Multiplier for mul; dividend shifting out / quotient shifting in for div.
  logic [W-1:0]   mplier_q, mplier_d;
  logic [W:0]     rem_q, rem_d;
  logic [2*W-1:0] result_q, result_d;
  logic [W-1:0]   remainder_q, remainder_d;
  logic           carry_q, carry_d;
  logic           neg_q, neg_d;
  logic           dbz_q, dbz_d;

  logic [W:0]     sum;
  logic           a_lt_b;
  logic [W-1:0]   diff;
  logic [2*W-1:0] acc_step;
  logic [W:0]     shifted;
  logic [W:0]     trial;
  logic           q_bit;
  logic [W:0]     rem_step;
  logic [W:0]     quo_shift;
  logic           last_step;

  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    a_lt_b    = (a_q < b_q);
    diff      = a_lt_b ? (b_q - a_q) : (a_q - b_q);
    acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    shifted   = {rem_q[W-1:0], mplier_q[W-1]};
    // Partial remainder stays below b, so bit W of the trial is a clean borrow.
    trial     = shifted - {1'b0, b_q};
    q_bit     = ~trial[W];
    rem_step  = q_bit ? trial : shifted;
    quo_shift = {mplier_q, q_bit};
    last_step = (count_q == CW'(W - 1));
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    rem_d       = rem_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    carry_d     = carry_q;
    neg_d       = neg_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d              = a;
          b_d              = b;
          op_d             = op;
          count_d          = '0;
          acc_d            = '0;
          rem_d            = '0;
          mcand_d          = '0;
          mcand_d[W-1:0]   = a;
          mplier_d         = (op == OP_DIV) ? a : b;
          state_d          = EXEC;
        end
      end

      EXEC: begin
        case (op_q)
          OP_ADD: begin
            state_d        = DONE;
            result_d       = '0;
            result_d[W:0]  = sum;
            remainder_d    = '0;
            carry_d        = sum[W];
            neg_d          = 1'b0;
            dbz_d          = 1'b0;
          end
          OP_SUB: begin
            state_d          = DONE;
            result_d         = '0;
            result_d[W-1:0]  = diff;
            remainder_d      = '0;
            carry_d          = 1'b0;
            neg_d            = a_lt_b;
            dbz_d            = 1'b0;
          end
          OP_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            if (last_step) begin
              state_d     = DONE;
              result_d    = acc_step;
              remainder_d = '0;
              carry_d     = 1'b0;
              neg_d       = 1'b0;
              dbz_d       = 1'b0;
            end
          end
          default: begin
            if (b_q == '0) begin
              state_d     = DONE;
              result_d    = '0;
              remainder_d = '0;
              carry_d     = 1'b0;
              neg_d       = 1'b0;
              dbz_d       = 1'b1;
            end else begin
              rem_d    = rem_step;
              mplier_d = quo_shift[W-1:0];
              count_d  = count_q + CW'(1);
              if (last_step) begin
                state_d          = DONE;
                result_d         = '0;
                result_d[W-1:0]  = quo_shift[W-1:0];
                remainder_d      = rem_step[W-1:0];
                carry_d          = 1'b0;
                neg_d            = 1'b0;
                dbz_d            = 1'b0;
              end
            end
          end
        endcase
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      carry_q     <= 1'b0;
      neg_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      carry_q     <= carry_d;
      neg_q       <= neg_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign result      = result_q;
  assign remainder   = remainder_q;
  assign carry       = carry_q;
  assign neg         = neg_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_reader.sv
// Directed bench for alu_seq_reader (W=4): latency, results, flags, ignored start, async reset.
module tb_alu_seq_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [3:0] remainder;
  logic       carry;
  logic       neg;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  alu_seq_reader #(.W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .remainder  (remainder),
    .carry      (carry),
    .neg        (neg),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge, then returns the number of edges until done (bounded).
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic [1:0] iop,
                        output int lat);
    a = ia; b = ib; op = iop; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  int         lat;
  int         dcnt;
  int         dlat;
  logic [7:0] rsnap;
  logic [3:0] remsnap;

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 4'd0; b = 4'd0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_flags", {carry, neg, div_by_zero}, 0);
    reset = 1'b0;
    tick();

    // Add 9+8: done one edge after the sampling edge.
    a = 4'd9; b = 4'd8; op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    chk("add_busy_exec", busy, 1);
    chk("add_done_early", done, 0);
    tick();
    chk("add_done", done, 1);
    chk("add_result", result, 8'h11);
    chk("add_carry", carry, 1);
    chk("add_neg", neg, 0);
    tick();
    chk("add_done_drop", done, 0);
    chk("add_busy_idle", busy, 0);
    chk("add_result_hold", result, 8'h11);

    run_op(4'd7, 4'd3, 2'b01, lat);
    chk("sub73_lat", lat, 1);
    chk("sub73_result", result, 4);
    chk("sub73_neg", neg, 0);
    chk("sub73_carry", carry, 0);
    tick();

    run_op(4'd3, 4'd7, 2'b01, lat);
    chk("sub37_lat", lat, 1);
    chk("sub37_result", result, 4);
    chk("sub37_neg", neg, 1);
    tick();

    // Mul 15*15 with operand changes and a second start while in EXEC.
    a = 4'd15; b = 4'd15; op = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    dcnt = 0; dlat = -1; rsnap = '0; remsnap = '1;
    for (int e = 1; e <= 8; e++) begin
      if (e == 1) begin a = 4'd1; b = 4'd1; end
      if (e == 2) start = 1'b1;
      tick();
      if (e == 2) start = 1'b0;
      if (done === 1'b1) begin
        dcnt++;
        dlat = e;
        rsnap = result;
        remsnap = remainder;
      end
    end
    chk("mul_done_count", dcnt, 1);
    chk("mul_lat", dlat, 4);
    chk("mul_result", rsnap, 8'hE1);
    chk("mul_remainder", remsnap, 0);
    chk("mul_neg_cleared", neg, 0);
    chk("mul_result_hold", result, 8'hE1);
    chk("mul_busy_idle", busy, 0);

    run_op(4'd5, 4'd0, 2'b11, lat);
    chk("dz_lat", lat, 1);
    chk("dz_result", result, 0);
    chk("dz_remainder", remainder, 0);
    chk("dz_flag", div_by_zero, 1);
    tick();

    run_op(4'd13, 4'd4, 2'b11, lat);
    chk("div_lat", lat, 4);
    chk("div_result", result, 3);
    chk("div_remainder", remainder, 1);
    chk("div_dz_cleared", div_by_zero, 0);
    tick();

    // Reset while a mul sits at count=2.
    a = 4'd15; b = 4'd15; op = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("midmul_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_remainder", remainder, 0);
    tick();
    reset = 1'b0;
    dcnt = 0;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    chk("arst_no_done", dcnt, 0);

    run_op(4'd6, 4'd7, 2'b10, lat);
    chk("mul67_lat", lat, 4);
    chk("mul67_result", result, 42);
    tick();
    chk("mul67_busy_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
